seq_control_unit: RTL and testbench

Parametrised multicycle controller for the register-file / ALU datapath. It fetches one instruction word, decodes the opcode, and sequences per-opcode micro-steps driving IR, A, C and register enables, the bus mux select, and the ALU op. It supports variable latency per opcode, a data-valid handshake for immediate loads, and flagging of illegal opcodes.

---
 rtl/seq_control_unit_pkg.sv | 29 ++
 rtl/seq_control_unit_if.sv | 29 ++
 rtl/seq_control_unit_reg_wr_decoder.sv | 15 +
 rtl/seq_control_unit.sv | 75 +++++++
 tb/tb_seq_control_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seq_control_unit_pkg.sv
// seq_control_unit_pkg: opcodes, state enum, field extraction and mux offsets for seq_control_unit
package seq_cu_pkg;
  localparam logic [1:0] OPC_MV  = 2'b00;
  localparam logic [1:0] OPC_MVI = 2'b01;
  localparam logic [1:0] OPC_ALU = 2'b10;
  localparam logic [1:0] OPC_RSV = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MV, S_IMM, S_ALU_A, S_ALU_B, S_WRITE} state_t;
  function automatic int unsigned field(input logic [31:0] w, input int unsigned lsb, input int unsigned width);
    return (w >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction
  function automatic int unsigned rx_of(input logic [31:0] w, input int unsigned instr_w, input int unsigned reg_aw);
    return field(w, instr_w - reg_aw, reg_aw);
  endfunction
  function automatic int unsigned ry_of(input logic [31:0] w, input int unsigned instr_w, input int unsigned reg_aw);
    return field(w, instr_w - 2 * reg_aw, reg_aw);
  endfunction
  function automatic int unsigned alu_of(input logic [31:0] w, input int unsigned alu_w);
    return field(w, 2, alu_w);
  endfunction
  function automatic int unsigned opc_of(input logic [31:0] w);
    return field(w, 0, 2);
  endfunction
  function automatic int unsigned mux_c(input int unsigned num_regs);
    return num_regs;
  endfunction
  function automatic int unsigned mux_din(input int unsigned num_regs);
    return num_regs + 1;
  endfunction
endpackage

// File: rtl/seq_control_unit_if.sv
// seq_control_unit_if: control/handshake bundle between the sequencer (master) and the datapath (slave)
interface seq_control_unit_if #(
  parameter int NUM_REGS  = 8,
  parameter int INSTR_W   = 16,
  parameter int ALU_SEL_W = 3
);
  localparam int MUX_W = $clog2(NUM_REGS + 2);
  logic                 run;
  logic [INSTR_W-1:0]   instruction;
  logic                 din_valid;
  logic                 en_i;
  logic                 en_s;
  logic                 en_c;
  logic [NUM_REGS-1:0]  en_r;
  logic [MUX_W-1:0]     mux_sel;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic                 done;
  logic                 busy;
  logic                 illegal;
  logic [15:0]          retired;
  modport master (
    input  run, instruction, din_valid,
    output en_i, en_s, en_c, en_r, mux_sel, alu_sel, done, busy, illegal, retired
  );
  modport slave (
    output run, instruction, din_valid,
    input  en_i, en_s, en_c, en_r, mux_sel, alu_sel, done, busy, illegal, retired
  );
endinterface

// File: rtl/seq_control_unit_reg_wr_decoder.sv
// reg_wr_decoder: register index plus enable to one-hot register write enables
module reg_wr_decoder #(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3
) (
  input  logic [REG_AW-1:0]   idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);
  // at most one write enable, selected by idx
  always_comb begin
    onehot      = '0;
    onehot[idx] = en;
  end
endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: multicycle fetch/decode/execute sequencer; SEQ_CU_RETIRE_CNT_EN adds a retired-instruction counter
module seq_control_unit
  import seq_cu_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int INSTR_W   = 16,
  parameter int ALU_SEL_W = 3
) (
  input logic               clk,
  input logic               reset,
  seq_control_unit_if.master bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int MUX_W  = $clog2(NUM_REGS + 2);
  state_t               state;
  logic [INSTR_W-1:0]   ir;
  logic [REG_AW-1:0]    rx;
  logic [REG_AW-1:0]    ry;
  logic [ALU_SEL_W-1:0] alu;
  logic [1:0]           live_opc;
  logic                 wr_en;
  // sequencer: dropping run aborts to IDLE; FETCH decodes the live bus while ir latches it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      if (state == S_FETCH) ir <= bus.instruction;
      if (!bus.run) state <= S_IDLE;
      else case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: state <= live_opc == OPC_MV ? S_MV : live_opc == OPC_MVI ? S_IMM : live_opc == OPC_ALU ? S_ALU_A : S_IDLE;
        S_IMM:   state <= bus.din_valid ? S_IDLE : S_IMM;
        S_ALU_A: state <= S_ALU_B;
        S_ALU_B: state <= S_WRITE;
        default: state <= S_IDLE;
      endcase
    end
  end
  // output decode from state and latched instruction; IMM writes only when the immediate is present
  always_comb begin
    rx           = REG_AW'(rx_of(32'(ir), INSTR_W, REG_AW));
    ry           = REG_AW'(ry_of(32'(ir), INSTR_W, REG_AW));
    alu          = ALU_SEL_W'(alu_of(32'(ir), ALU_SEL_W));
    live_opc     = 2'(opc_of(32'(bus.instruction)));
    bus.en_i     = state == S_FETCH;
    bus.en_s     = state == S_ALU_A;
    bus.en_c     = state == S_ALU_B;
    bus.alu_sel  = state == S_ALU_B ? alu : '0;
    bus.mux_sel  = state == S_ALU_A ? MUX_W'(rx) :
                   state == S_ALU_B || state == S_MV ? MUX_W'(ry) :
                   state == S_IMM ? MUX_W'(mux_din(NUM_REGS)) :
                   state == S_WRITE ? MUX_W'(mux_c(NUM_REGS)) : '0;
    wr_en        = state == S_MV || state == S_WRITE || (state == S_IMM && bus.din_valid);
    bus.illegal  = state == S_FETCH && live_opc == OPC_RSV;
    bus.done     = wr_en || bus.illegal;
    bus.busy     = state != S_IDLE;
  end
  reg_wr_decoder #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW)) u_wr_dec (
    .idx   (rx),
    .en    (wr_en),
    .onehot(bus.en_r)
  );
`ifdef SEQ_CU_RETIRE_CNT_EN
  logic [15:0] retired_q;
  // counts every retire, illegal included, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else if (bus.done) retired_q <= retired_q + 16'd1;
  end
  assign bus.retired = retired_q;
`else
  assign bus.retired = '0;
`endif
endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: directed stimulus, step-queue reference model checked every cycle plus literal spot checks
module tb_seq_control_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  seq_control_unit_if #(.NUM_REGS(8), .INSTR_W(16), .ALU_SEL_W(3)) bus();
  seq_control_unit #(.NUM_REGS(8), .INSTR_W(16), .ALU_SEL_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
`ifdef SEQ_CU_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  typedef struct {
    bit         fetch;
    bit         imm;
    bit         en_i;
    bit         en_s;
    bit         en_c;
    logic [7:0] er;
    logic [3:0] mux;
    logic [2:0] alu;
    bit         done;
  } step_t;
  step_t q[$];
  int unsigned m_ret = 0;
  function automatic step_t mk(bit f, bit im, bit i, bit s, bit c, logic [7:0] er, logic [3:0] mux, logic [2:0] alu, bit d);
    step_t r;
    r.fetch = f; r.imm = im; r.en_i = i; r.en_s = s; r.en_c = c;
    r.er = er; r.mux = mux; r.alu = alu; r.done = d;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, got, want);
    end
  endtask
  // reference: a queue of expected micro-steps per instruction, advanced once per cycle
  always @(negedge clk) if (chk_en) begin
    step_t e;
    logic [15:0] ins;
    logic [7:0] tgt;
    bit ill;
    ins = bus.instruction;
    e = q.size() != 0 ? q[0] : mk(0, 0, 0, 0, 0, 8'h00, 4'd0, 3'd0, 0);
    ill = e.fetch && ins[1:0] == 2'b11;
    if (ill) e.done = 1'b1;
    if (e.imm && !bus.din_valid) begin
      e.er = 8'h00;
      e.done = 1'b0;
    end
    chk("en_i", bus.en_i, e.en_i);
    chk("en_s", bus.en_s, e.en_s);
    chk("en_c", bus.en_c, e.en_c);
    chk("en_r", bus.en_r, e.er);
    chk("mux_sel", bus.mux_sel, e.mux);
    chk("alu_sel", bus.alu_sel, e.alu);
    chk("done", bus.done, e.done);
    chk("illegal", bus.illegal, ill);
    chk("busy", bus.busy, q.size() != 0);
    chk("retired", bus.retired, CNT_EN ? m_ret : 0);
    if (reset) begin
      q.delete();
      m_ret = 0;
    end else if (q.size() == 0) begin
      if (bus.run) q.push_back(mk(1, 0, 1, 0, 0, 8'h00, 4'd0, 3'd0, 0));
    end else begin
      if (e.done) m_ret = (m_ret + 1) & 32'hFFFF;
      if (!bus.run) q.delete();
      else begin
        if (!e.imm || bus.din_valid) void'(q.pop_front());
        if (e.fetch) begin
          tgt = 8'h01 << ins[15:13];
          case (ins[1:0])
            2'b00: q.push_back(mk(0, 0, 0, 0, 0, tgt, {1'b0, ins[12:10]}, 3'd0, 1));
            2'b01: q.push_back(mk(0, 1, 0, 0, 0, tgt, 4'd9, 3'd0, 1));
            2'b10: begin
              q.push_back(mk(0, 0, 0, 1, 0, 8'h00, {1'b0, ins[15:13]}, 3'd0, 0));
              q.push_back(mk(0, 0, 0, 0, 1, 8'h00, {1'b0, ins[12:10]}, ins[4:2], 0));
              q.push_back(mk(0, 0, 0, 0, 0, tgt, 4'd8, 3'd0, 1));
            end
            default: ;
          endcase
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [15:0] mv_ins [3] = '{16'h3800, 16'hB400, 16'hE000};
  logic [7:0]  mv_er  [3] = '{8'h02, 8'h20, 8'h80};
  logic [3:0]  mv_mux [3] = '{4'd6, 4'd5, 4'd0};
  initial begin
    reset = 1'b1;
    bus.run = 1'b0;
    bus.instruction = 16'h0000;
    bus.din_valid = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    bus.instruction = 16'h680A;
    bus.run = 1'b1;
    #5 chk("rst_busy", bus.busy, 0); chk("rst_en_r", bus.en_r, 0); chk("rst_done", bus.done, 0); chk("rst_retired", bus.retired, 0);
    step(); #5 chk("alu_fetch_en_i", bus.en_i, 1); chk("alu_fetch_busy", bus.busy, 1);
    step(); #5 chk("alu_a_en_s", bus.en_s, 1); chk("alu_a_mux", bus.mux_sel, 3);
    step(); #5 chk("alu_b_en_c", bus.en_c, 1); chk("alu_b_mux", bus.mux_sel, 2); chk("alu_b_sel", bus.alu_sel, 2);
    step(); bus.run = 1'b0;
    #5 chk("alu_wr_mux", bus.mux_sel, 8); chk("alu_wr_en_r", bus.en_r, 8'h08); chk("alu_wr_done", bus.done, 1);
    step(); bus.instruction = 16'h3800; bus.run = 1'b1;
    #5 chk("alu_idle_busy", bus.busy, 0);
    step(); #5 chk("mv_fetch_en_i", bus.en_i, 1);
    step(); bus.run = 1'b0;
    #5 chk("mv_mux", bus.mux_sel, 6); chk("mv_en_r", bus.en_r, 8'h02); chk("mv_done", bus.done, 1);
    step(); bus.instruction = 16'hE001; bus.run = 1'b1;
    #5 chk("mv_idle_busy", bus.busy, 0);
    step(); #5 chk("mvi_fetch_en_i", bus.en_i, 1);
    repeat (3) begin
      step(); #5 chk("mvi_stall_en_r", bus.en_r, 0); chk("mvi_stall_mux", bus.mux_sel, 9); chk("mvi_stall_done", bus.done, 0);
    end
    step(); bus.din_valid = 1'b1; bus.run = 1'b0;
    #5 chk("mvi_en_r", bus.en_r, 8'h80); chk("mvi_done", bus.done, 1);
    step(); bus.din_valid = 1'b0; bus.instruction = 16'h4003; bus.run = 1'b1;
    #5 chk("mvi_idle_busy", bus.busy, 0);
    step(); bus.run = 1'b0;
    #5 chk("ill_done", bus.done, 1); chk("ill_flag", bus.illegal, 1); chk("ill_en_r", bus.en_r, 0);
    step(); bus.instruction = 16'h680A; bus.run = 1'b1;
    #5 chk("ill_busy", bus.busy, 0); chk("ill_retired", bus.retired, CNT_EN ? 4 : 0);
    step(); #5 chk("abt_fetch", bus.en_i, 1);
    step(); bus.run = 1'b0;
    #5 chk("abt_en_s", bus.en_s, 1); chk("abt_mux", bus.mux_sel, 3);
    step(); #5 chk("abt_busy", bus.busy, 0); chk("abt_en_c", bus.en_c, 0);
    step(); bus.run = 1'b1;
    #5 chk("abt_idle_done", bus.done, 0);
    step(); #5 chk("rb_fetch", bus.en_i, 1);
    step(); #5 chk("rb_alu_a", bus.en_s, 1);
    step(); reset = 1'b1;
    #5 chk("rb_alu_b", bus.en_c, 1);
    step(); reset = 1'b0; bus.instruction = mv_ins[0];
    #5 chk("rb_busy", bus.busy, 0); chk("rb_en_c", bus.en_c, 0); chk("rb_en_r", bus.en_r, 0); chk("rb_mux", bus.mux_sel, 0); chk("rb_retired", bus.retired, 0);
    for (int k = 0; k < 3; k++) begin
      step(); #5 chk("b2b_fetch", bus.en_i, 1);
      step(); if (k == 2) bus.run = 1'b0;
      #5 chk("b2b_done", bus.done, 1); chk("b2b_en_r", bus.en_r, mv_er[k]); chk("b2b_mux", bus.mux_sel, mv_mux[k]);
      step(); if (k < 2) bus.instruction = mv_ins[k + 1];
      #5 chk("b2b_gap_done", bus.done, 0); chk("b2b_gap_busy", bus.busy, 0);
    end
    chk("b2b_retired", bus.retired, CNT_EN ? 3 : 0);
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
